// File: rtl/kbd_event_fifo.sv
// PS/2 scancode prefix parser feeding a first-word-fall-through event FIFO.
// Optional error-strobe counter enabled by defining KBD_ERR_COUNT_EN.
module kbd_event_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic [7:0]               ps2_code_i,
    input  logic                     ps2_strobe_i,
    input  logic                     ps2_err_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [7:0]               evt_code_o,
    output logic                     evt_ext_o,
    output logic                     evt_brk_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     clr_overflow_i
`ifdef KBD_ERR_COUNT_EN
    ,
    output logic [7:0]               err_count_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t          state_r;
    logic [9:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            valid_r;
    logic [9:0]      head_r;
    logic            overflow_r;

    logic            push_req_s;
    logic [9:0]      push_data_s;
    logic            pop_s;
    logic            full_s;
    logic            push_s;
    logic            drop_s;
    logic [AW-1:0]   rd_ptr_nxt_s;
    logic [CW-1:0]   count_nxt_s;
    logic [9:0]      head_nxt_s;

    // Decode a completed (non-prefix, error-free) byte into an event word {ext, brk, code}.
    always_comb begin
        push_req_s  = 1'b0;
        push_data_s = {(state_r == ST_EXT) || (state_r == ST_EXT_BRK),
                       (state_r == ST_BRK) || (state_r == ST_EXT_BRK),
                       ps2_code_i};
        if (ps2_strobe_i && !ps2_err_i && (ps2_code_i != 8'hE0) && (ps2_code_i != 8'hF0)) begin
            push_req_s = 1'b1;
        end else begin
            push_req_s = 1'b0;
        end
    end

    // Prefix parser: E0 always restarts an extended sequence, F0 marks a release.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_IDLE;
        end else if (ps2_strobe_i) begin
            if (ps2_err_i) begin
                state_r <= ST_IDLE;
            end else begin
                case (ps2_code_i)
                    8'hE0: state_r <= ST_EXT;
                    8'hF0: begin
                        case (state_r)
                            ST_IDLE:    state_r <= ST_BRK;
                            ST_EXT:     state_r <= ST_EXT_BRK;
                            ST_BRK:     state_r <= ST_BRK;
                            ST_EXT_BRK: state_r <= ST_EXT_BRK;
                            default:    state_r <= ST_IDLE;
                        endcase
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end else begin
            state_r <= state_r;
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_s        = valid_r & evt_ready_i;
        full_s       = (count_r == CW'(DEPTH));
        push_s       = push_req_s & (~full_s | pop_s);
        drop_s       = push_req_s & full_s & ~pop_s;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // Bypass storage when the word being written becomes the head this cycle.
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Event storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            head_r     <= 10'd0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            valid_r  <= (count_nxt_s != CW'(0));
            if (count_nxt_s != CW'(0)) begin
                head_r <= head_nxt_s;
            end else begin
                head_r <= head_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

`ifdef KBD_ERR_COUNT_EN
    logic [7:0] err_count_r;

    // Saturating count of strobes flagged with a receiver error.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_count_r <= 8'd0;
        end else if (ps2_strobe_i && ps2_err_i && (err_count_r != 8'd255)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count_o = err_count_r;
`endif

    assign evt_valid_o = valid_r;
    assign evt_ext_o   = head_r[9];
    assign evt_brk_o   = head_r[8];
    assign evt_code_o  = head_r[7:0];
    assign count_o     = count_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Self-checking bench for kbd_event_fifo: table-driven parser vectors plus
// hand-written FIFO full/overflow/reset sequences, checked through a scoreboard queue.
module tb_kbd_event_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n_i;
    logic [7:0] ps2_code_i;
    logic       ps2_strobe_i;
    logic       ps2_err_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [7:0] evt_code_o;
    logic       evt_ext_o;
    logic       evt_brk_o;
    logic [2:0] count_o;
    logic       overflow_o;
    logic       clr_overflow_i;
`ifdef KBD_ERR_COUNT_EN
    logic [7:0] err_count_o;
`endif

    int tests_run;
    int tests_failed;
    logic [9:0] sb_q[$];

    kbd_event_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .ps2_code_i     (ps2_code_i),
        .ps2_strobe_i   (ps2_strobe_i),
        .ps2_err_i      (ps2_err_i),
        .evt_valid_o    (evt_valid_o),
        .evt_ready_i    (evt_ready_i),
        .evt_code_o     (evt_code_o),
        .evt_ext_o      (evt_ext_o),
        .evt_brk_o      (evt_brk_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .clr_overflow_i (clr_overflow_i)
`ifdef KBD_ERR_COUNT_EN
        ,
        .err_count_o    (err_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake monitor: inputs change only at #1 after posedge, so negedge sees what the next edge will.
    always @(negedge clk) begin
        if (reset_n_i && evt_valid_o && evt_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {evt_ext_o, evt_brk_o, evt_code_o}, 0);
            end else begin
                logic [9:0] e;
                e = sb_q.pop_front();
                chk("evt_code", evt_code_o, e[7:0]);
                chk("evt_ext", evt_ext_o, e[9]);
                chk("evt_brk", evt_brk_o, e[8]);
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic e);
        ps2_code_i   = c;
        ps2_err_i    = e;
        ps2_strobe_i = 1'b1;
        @(posedge clk); #1;
        ps2_strobe_i = 1'b0;
        ps2_err_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, evt_valid_o, 0);
        chk({tag, "_code"}, evt_code_o, 0);
        chk({tag, "_ext"}, evt_ext_o, 0);
        chk({tag, "_brk"}, evt_brk_o, 0);
        chk({tag, "_count"}, count_o, 0);
        chk({tag, "_overflow"}, overflow_o, 0);
    endtask

    typedef struct {
        logic [7:0] code;
        logic       err;
        logic       push;
        logic       ext;
        logic       brk;
    } vec_t;

    vec_t vecs[22];

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset_n_i      = 1'b0;
        ps2_code_i     = 8'h00;
        ps2_strobe_i   = 1'b0;
        ps2_err_i      = 1'b0;
        evt_ready_i    = 1'b0;
        clr_overflow_i = 1'b0;

        //             code   err   push  ext   brk
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h12, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{8'h4A, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{8'h70, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b0};

        #12;
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        idle(1);
        chk_zero_outputs("post_reset");

        // Parser vectors with a consumer that is always ready.
        evt_ready_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].push) begin
                sb_q.push_back({vecs[i].ext, vecs[i].brk, vecs[i].code});
            end
            send(vecs[i].code, vecs[i].err);
            chk($sformatf("vec%0d_valid", i), evt_valid_o, vecs[i].push);
        end
        idle(2);
        chk("table_drained_count", count_o, 0);
        chk("table_sb_empty", sb_q.size(), 0);
`ifdef KBD_ERR_COUNT_EN
        chk("err_count_two", err_count_o, 2);
`endif

        // Code/error without strobe must be ignored.
        ps2_code_i = 8'hE0;
        ps2_err_i  = 1'b1;
        idle(1);
        ps2_err_i  = 1'b0;
        sb_q.push_back({1'b0, 1'b0, 8'h15});
        send(8'h15, 1'b0);
        chk("nostrobe_valid", evt_valid_o, 1);
        idle(2);
`ifdef KBD_ERR_COUNT_EN
        chk("err_count_nostrobe", err_count_o, 2);
`endif

        // Fill with the consumer stalled; the last two events are dropped.
        evt_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= DEPTH) sb_q.push_back({2'b00, 8'(i)});
            send(8'(i), 1'b0);
        end
        chk("full_count", count_o, DEPTH);
        chk("full_overflow", overflow_o, 1);
        chk("full_head_held", evt_code_o, 8'h01);
        chk("full_valid", evt_valid_o, 1);

        // Drop and clear together: the set wins.
        clr_overflow_i = 1'b1;
        send(8'h07, 1'b0);
        clr_overflow_i = 1'b0;
        chk("ovf_set_priority", overflow_o, 1);
        clr_overflow_i = 1'b1;
        idle(1);
        clr_overflow_i = 1'b0;
        chk("ovf_cleared", overflow_o, 0);
        chk("ovf_clear_count", count_o, DEPTH);

        // Full FIFO with simultaneous pop and push.
        evt_ready_i = 1'b1;
        sb_q.push_back({2'b00, 8'h08});
        send(8'h08, 1'b0);
        chk("pushpop_count", count_o, DEPTH);
        chk("pushpop_overflow", overflow_o, 0);
        chk("pushpop_head", evt_code_o, 8'h02);
        idle(DEPTH + 2);
        chk("drain_count", count_o, 0);
        chk("drain_valid", evt_valid_o, 0);
        chk("drain_sb_empty", sb_q.size(), 0);

        // Reset mid-operation with a stored event and a pending E0 prefix.
        evt_ready_i = 1'b0;
        send(8'h22, 1'b0);
        send(8'hE0, 1'b0);
        #3;
        reset_n_i = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        sb_q.delete();
        @(posedge clk); #1;
        chk("midrst_hold_valid", evt_valid_o, 0);
        chk("midrst_hold_count", count_o, 0);
`ifdef KBD_ERR_COUNT_EN
        chk("midrst_err_count", err_count_o, 0);
`endif
        reset_n_i   = 1'b1;
        idle(1);
        evt_ready_i = 1'b1;
        sb_q.push_back({1'b0, 1'b0, 8'h6B});
        send(8'h6B, 1'b0);
        chk("postrst_valid", evt_valid_o, 1);
        chk("postrst_ext", evt_ext_o, 0);
        idle(3);
        chk("postrst_sb_empty", sb_q.size(), 0);
        chk("postrst_count", count_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
